// File: rtl/down_counter_4bit_pkg.sv
// Shared definitions for the loadable down counter: state encoding and default width.
package down_counter_4bit_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/down_counter_4bit_decrement_by_1.sv
// Combinational x -> x-1 with unsigned borrow (0 -> all-ones) and signed overflow flags.
module decrement_by_1 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             borrow,
   output logic             overflow
);

   logic [WIDTH:0]          diff;
   logic signed [WIDTH-1:0] xs;
   logic signed [WIDTH-1:0] ys;

   assign diff   = {1'b0, x} - {{WIDTH{1'b0}}, 1'b1};
   assign y      = diff[WIDTH-1:0];
   assign borrow = diff[WIDTH];

   // Only the most-negative value can turn positive when decremented.
   assign xs       = x;
   assign ys       = diff[WIDTH-1:0];
   assign overflow = xs[WIDTH-1] & ~ys[WIDTH-1];

endmodule

// File: rtl/down_counter_4bit.sv
// Loadable down counter with one-shot / free-run modes, stop, and registered status pulses.
module down_counter_4bit
   import down_counter_4bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             borrow,
   output logic             overflow
);

   state_t           state;
   logic             mode_lat;
   logic [WIDTH-1:0] dec_q;
   logic             dec_borrow;
   logic             dec_ovf;

   decrement_by_1 #(
      .WIDTH (WIDTH)
   ) u_dec (
      .x        (q),
      .y        (dec_q),
      .borrow   (dec_borrow),
      .overflow (dec_ovf)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         q        <= '0;
         mode_lat <= 1'b0;
         borrow   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         borrow   <= 1'b0;
         overflow <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  q <= din;
               end else if (start) begin
                  mode_lat <= mode;
                  if ((q != '0) || mode) state <= ST_RUN;
                  else                   state <= ST_DONE;
               end
            end
            ST_RUN: begin
               // Stop outranks both the decrement and the terminal-count transition.
               if (stop) begin
                  state <= ST_IDLE;
               end else if (!mode_lat && (q == '0)) begin
                  state <= ST_DONE;
               end else begin
                  q        <= dec_q;
                  borrow   <= dec_borrow;
                  overflow <= dec_ovf;
                  if (!mode_lat && (q == WIDTH'(1))) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               if (load) q <= din;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule
